// File: rtl/data_cache_ctrl.sv
// Direct-mapped write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when CACHE_STATS_EN is defined.
module data_cache_ctrl #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        read_en,
    input  logic        write_en,
    input  logic        half,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
`ifdef CACHE_STATS_EN
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt,
`endif
    input  logic        mem_ready
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  in_idle;
    logic                  fill_done;
    logic                  write_hit;
    logic [31:0]           line_word;
    logic [31:0]           src_word;
    logic [15:0]           half_sel;
    logic [31:0]           merged;
    logic [3:0]            lane_be;
    logic                  stall_c;
    logic                  req_c;
    logic                  we_c;
    logic [3:0]            be_c;
    logic                  unused_addr0;

    assign idx       = addr[INDEX_BITS+1:2];
    assign tag       = addr[31:INDEX_BITS+2];
    assign hit       = valid_q[idx] && (tag_q[idx] == tag);
    assign in_idle   = (state_q == IDLE);
    assign fill_done = (state_q == FILL) && mem_ready;
    assign write_hit = in_idle && write_en && hit;
    assign line_word = data_q[idx];
    assign unused_addr0 = addr[0];

    // During FILL the load is served straight from the memory bus.
    assign src_word = (state_q == FILL) ? mem_rdata : line_word;
    assign half_sel = addr[1] ? src_word[31:16] : src_word[15:0];
    assign rdata    = half ? {{16{half_sel[15]}}, half_sel} : src_word;

    assign merged = !half   ? wdata :
                    addr[1] ? {wdata[15:0], line_word[15:0]} :
                              {line_word[31:16], wdata[15:0]};

    assign lane_be   = !half ? 4'b1111 : (addr[1] ? 4'b1100 : 4'b0011);
    assign mem_addr  = {addr[31:2], 2'b00};
    assign mem_wdata = !half   ? wdata :
                       addr[1] ? {wdata[15:0], 16'h0000} :
                                 {16'h0000, wdata[15:0]};

    always_comb begin
        state_d = state_q;
        stall_c = 1'b0;
        req_c   = 1'b0;
        we_c    = 1'b0;
        be_c    = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (write_en) begin
                    stall_c = 1'b1;
                    state_d = WRITE;
                end else if (read_en && !hit) begin
                    stall_c = 1'b1;
                    state_d = FILL;
                end
            end
            FILL: begin
                req_c   = 1'b1;
                be_c    = 4'b1111;
                stall_c = ~mem_ready;
                if (mem_ready) state_d = IDLE;
            end
            WRITE: begin
                req_c   = 1'b1;
                we_c    = 1'b1;
                be_c    = lane_be;
                stall_c = ~mem_ready;
                if (mem_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset silences the bus and releases the CPU without waiting for a clock.
    assign stall   = stall_c & rst;
    assign mem_req = req_c & rst;
    assign mem_we  = we_c & rst;
    assign mem_be  = be_c & {4{rst}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (fill_done) valid_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= mem_rdata;
        end else if (write_hit) begin
            data_q[idx] <= merged;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    logic        rd_eval;

    assign rd_eval = in_idle && read_en && !write_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (rd_eval) begin
            if (hit && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
            if (!hit && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
        end
    end

    assign hit_cnt  = hit_q;
    assign miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: directed scenarios then random traffic
// checked against an address-level cache and memory model.
module tb_data_cache_ctrl;

    localparam int IB    = 4;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic        half = 1'b0;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    data_cache_ctrl #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
        .read_en(read_en), .write_en(write_en), .half(half),
        .rdata(rdata), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
`ifdef CACHE_STATS_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: cache lines and backing memory, addressed by arithmetic.
    bit          cv [LINES];
    logic [31:0] ct [LINES];
    logic [31:0] cd [LINES];
    logic [31:0] mem [int unsigned];
    int          hc = 0;
    int          mc = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        int unsigned w = a >> 2;
        if (mem.exists(w)) return mem[w];
        return (w * 32'h9E3779B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w,
                                             input logic [31:0] a,
                                             input bit hf);
        logic [15:0] h;
        if (!hf) return w;
        h = a[1] ? w[31:16] : w[15:0];
        return {{16{h[15]}}, h};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] a,
                                          input logic [31:0] wd,
                                          input bit hf);
        logic [31:0] r = old;
        if (!hf) return wd;
        if (a[1]) r[31:16] = wd[15:0];
        else r[15:0] = wd[15:0];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) cv[i] = 1'b0;
        hc = 0;
        mc = 0;
    endtask

    task automatic access(input bit rd, input bit wr, input bit hf,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int lat, output logic [31:0] got,
                          output int stalls);
        int          line = int'((a >> 2) % LINES);
        logic [31:0] tg = a >> (IB + 2);
        bit          hit = cv[line] && (ct[line] == tg);
        bit          is_rd = rd && !wr;
        bit          exp_stall = wr || (is_rd && !hit);
        logic [31:0] mw = mem_rd(a);
        logic [3:0]  be = !hf ? 4'b1111 : (a[1] ? 4'b1100 : 4'b0011);
        got = 'x;
        stalls = 0;
        @(negedge clk);
        addr = a; wdata = wd; read_en = rd; write_en = wr;
        half = hf; mem_ready = 1'b0;
        #1;
        chk("idle_stall", 32'(stall), 32'(exp_stall));
        chk("idle_req", 32'(mem_req), 32'd0);
        if (is_rd && hit) begin
            chk("hit_rdata", rdata, load_val(cd[line], a, hf));
            got = rdata;
            hc++;
        end
        if (wr && hit) cd[line] = merge(cd[line], a, wd, hf);
        if (exp_stall) begin
            stalls = 1;
            if (is_rd) mc++;
            for (int c = 0; c <= lat; c++) begin
                @(posedge clk);
                @(negedge clk);
                mem_ready = (c == lat);
                mem_rdata = (is_rd && c == lat) ? mw : $urandom;
                #1;
                chk("bus_req", 32'(mem_req), 32'd1);
                chk("bus_we", 32'(mem_we), 32'(wr));
                chk("bus_stall", 32'(stall), 32'(c != lat));
                chk("bus_addr", mem_addr, {a[31:2], 2'b00});
                if (wr) begin
                    chk("bus_be", 32'(mem_be), 32'(be));
                    if (!hf) chk("bus_wdata", mem_wdata, wd);
                    else if (a[1]) chk("bus_wdata_hi", 32'(mem_wdata[31:16]), 32'(wd[15:0]));
                    else chk("bus_wdata_lo", 32'(mem_wdata[15:0]), 32'(wd[15:0]));
                end
                if (is_rd && c == lat) begin
                    chk("fill_rdata", rdata, load_val(mw, a, hf));
                    got = rdata;
                end
                if (stall) stalls++;
            end
            if (is_rd) begin
                cv[line] = 1'b1;
                ct[line] = tg;
                cd[line] = mw;
            end else begin
                mem[a >> 2] = merge(mw, a, wd, hf);
            end
        end
        @(posedge clk);
    endtask

    task automatic idle_cycle(input bit pulse);
        @(negedge clk);
        read_en = 1'b0; write_en = 1'b0; half = 1'b0;
        mem_ready = pulse;
        mem_rdata = $urandom;
        #1;
        chk("quiet_stall", 32'(stall), 32'd0);
        chk("quiet_req", 32'(mem_req), 32'd0);
        chk("quiet_be", 32'(mem_be), 32'd0);
        @(posedge clk);
    endtask

    task automatic check_stats();
`ifdef CACHE_STATS_EN
        chk("hit_cnt", 32'(hit_cnt), 32'(hc));
        chk("miss_cnt", 32'(miss_cnt), 32'(mc));
`endif
    endtask

    logic [31:0] got;
    int          st;

    initial begin
        model_reset();
        // Reset state
        @(negedge clk);
        read_en = 1'b1;
        addr = 32'h40;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_be", 32'(mem_be), 32'd0);
        read_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle_cycle(1'b0);
        check_stats();

        // Miss with two wait cycles, then a hit
        mem[32'h40 >> 2] = 32'h12345678;
        access(1, 0, 0, 32'h40, 0, 2, got, st);
        chk("miss_stalls", 32'(st), 32'd3);
        chk("miss_data", got, 32'h12345678);
        access(1, 0, 0, 32'h40, 0, 0, got, st);
        chk("hit_stalls", 32'(st), 32'd0);
        chk("hit_data", got, 32'h12345678);

        // Halfword sign extension on a cached line
        access(0, 1, 0, 32'h40, 32'h8001_7FFF, 1, got, st);
        access(1, 0, 1, 32'h42, 0, 0, got, st);
        chk("lh_hi", got, 32'hFFFF8001);
        chk("lh_hi_stalls", 32'(st), 32'd0);
        access(1, 0, 1, 32'h40, 0, 0, got, st);
        chk("lh_lo", got, 32'h00007FFF);
        chk("lh_lo_stalls", 32'(st), 32'd0);

        // Halfword store merges into the upper half
        access(0, 1, 1, 32'h42, 32'h0000ABCD, 0, got, st);
        access(1, 0, 0, 32'h40, 0, 0, got, st);
        chk("sh_merge", got, 32'hABCD7FFF);

        // Store to an uncached line does not allocate
        idle_cycle(1'b1);
        access(0, 1, 0, 32'h80, 32'hCAFE_0001, 0, got, st);
        access(1, 0, 0, 32'h80, 0, 1, got, st);
        chk("no_alloc_stalls", 32'(st), 32'd2);
        chk("no_alloc_data", got, 32'hCAFE_0001);

        // Conflicting lines evict each other
        access(1, 0, 0, 32'h40, 0, 0, got, st);
        chk("conf_a_stalls", 32'(st), 32'd1);
        access(1, 0, 0, 32'h80, 0, 0, got, st);
        chk("conf_b_stalls", 32'(st), 32'd1);
        access(1, 0, 0, 32'h40, 0, 0, got, st);
        chk("conf_c_stalls", 32'(st), 32'd1);

        // Reset in the middle of a fill
        @(negedge clk);
        addr = 32'h1C0; read_en = 1'b1; write_en = 1'b0; half = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("mid_idle_stall", 32'(stall), 32'd1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("mid_fill_req", 32'(mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        model_reset();
        @(negedge clk);
        read_en = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        check_stats();
        access(1, 0, 0, 32'h1C0, 0, 0, got, st);
        chk("post_rst_stalls", 32'(st), 32'd1);
        access(1, 0, 0, 32'h40, 0, 0, got, st);
        chk("post_rst_evict", 32'(st), 32'd1);

        // Random traffic
        for (int i = 0; i < 250; i++) begin
            int          kind = $urandom_range(0, 9);
            bit          hf = 1'($urandom_range(0, 1));
            logic [31:0] a = 32'($urandom_range(0, 63)) * 4;
            int          lat = $urandom_range(0, 3);
            logic [31:0] wd = $urandom;
            if (hf && $urandom_range(0, 1) == 1) a = a + 2;
            if (kind <= 4) access(1, 0, hf, a, 0, lat, got, st);
            else if (kind <= 7) access(0, 1, hf, a, wd, lat, got, st);
            else if (kind == 8) access(1, 1, hf, a, wd, lat, got, st);
            else idle_cycle(1'($urandom_range(0, 1)));
        end
        idle_cycle(1'b0);
        check_stats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
